scan_display_driver: RTL

Parametrised, time-multiplexed driver for common-row LED displays (7-segment banks or dot-matrix rows). It scans `NUM_ROWS` rows of `ROW_W` segment bits from a flat frame vector and adds inter-row blanking for anti-ghosting, per-frame PWM brightness and a double-buffered frame load with handshake. It sits between the game graphics logic and the board's com/seg pins, and generalises the fixed 8×8 scanner used on the main display.

---
 rtl/scan_display_driver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/scan_display_driver.sv
// rtl/scan_display_driver.sv - time-multiplexed row/segment LED scanner
// Blanked row slots with per-frame PWM duty and a double-buffered frame load.
module scan_display_driver #(
  parameter int NUM_ROWS       = 8,
  parameter int ROW_W          = 8,
  parameter int PRESCALE       = 1,
  parameter int BLANK_CYC      = 1,
  parameter int BRIGHT_W       = 4,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_REVERSE    = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [NUM_ROWS*ROW_W-1:0] i_frame_data,
  input  logic                      i_load,
  input  logic [BRIGHT_W-1:0]       i_brightness,
  output logic [NUM_ROWS-1:0]       o_com,
  output logic [ROW_W-1:0]          o_seg,
  output logic                      o_frame_start,
  output logic                      o_load_ack
);
  localparam int SLOT = BLANK_CYC + (2**BRIGHT_W) - 1;
  localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW   = $clog2(SLOT + 1);
  localparam int FW   = NUM_ROWS * ROW_W;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE, S_DARK} state_t;

  state_t              r_state, w_state_nx;
  logic [FW-1:0]       r_stage, r_disp;
  logic                r_pend;
  logic [BRIGHT_W-1:0] r_bl;
  logic [RW-1:0]       r_row, w_row_nx;
  logic [PW-1:0]       r_pc, w_pc_nx;
  logic [TW-1:0]       r_t, w_t_nx;
  logic                w_tick, w_last, w_boundary, w_xfer;
  logic [ROW_W-1:0]    w_rows [NUM_ROWS];
  logic [ROW_W-1:0]    w_slice, w_seg_nx;
  logic [NUM_ROWS-1:0] w_onehot;

  assign w_tick = (int'(r_pc) == PRESCALE - 1);
  assign w_last = w_tick && (int'(r_t) == SLOT - 1);

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row;
    w_pc_nx    = r_pc;
    w_t_nx     = r_t;
    if (!i_enable) begin
      w_state_nx = S_IDLE;
      w_row_nx   = '0;
      w_pc_nx    = '0;
      w_t_nx     = '0;
    end else if (r_state == S_IDLE) begin
      w_state_nx = S_BLANK;
      w_row_nx   = '0;
      w_pc_nx    = '0;
      w_t_nx     = '0;
    end else begin
      w_pc_nx = w_tick ? '0 : r_pc + PW'(1);
      if (w_last) begin
        w_state_nx = S_BLANK;
        w_t_nx     = '0;
        w_row_nx   = (int'(r_row) == NUM_ROWS - 1) ? '0 : r_row + RW'(1);
      end else if (w_tick) begin
        w_t_nx = r_t + TW'(1);
        case (r_state)
          S_BLANK: if (int'(r_t) == BLANK_CYC - 1)
                     w_state_nx = (r_bl != '0) ? S_DRIVE : S_DARK;
          S_DRIVE: if (int'(r_t) == BLANK_CYC + int'(r_bl) - 1)
                     w_state_nx = S_DARK;
          default: ;
        endcase
      end
    end
  end

  // Frame boundary: entering the row-0 blank slot, either from IDLE or by wrapping.
  assign w_boundary = i_enable && ((r_state == S_IDLE) || (w_last && (w_row_nx == '0)));
  assign w_xfer     = r_pend && ((r_state == S_IDLE) || w_boundary);

  // Row 0 is the most-significant slice and drives the most-significant com line.
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_rows
    assign w_rows[g]   = r_disp[(NUM_ROWS-g)*ROW_W-1 -: ROW_W];
    assign w_onehot[g] = (w_row_nx == RW'(NUM_ROWS - 1 - g));
  end

  assign w_slice = w_rows[w_row_nx];

  for (genvar b = 0; b < ROW_W; b++) begin : g_seg
    assign w_seg_nx[b] = SEG_REVERSE ? w_slice[ROW_W-1-b] : w_slice[b];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_pc          <= '0;
      r_t           <= '0;
      r_stage       <= '0;
      r_disp        <= '0;
      r_pend        <= 1'b0;
      r_bl          <= '0;
      o_com         <= {NUM_ROWS{COM_ACTIVE_LOW}};
      o_seg         <= '0;
      o_frame_start <= 1'b0;
      o_load_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_row         <= w_row_nx;
      r_pc          <= w_pc_nx;
      r_t           <= w_t_nx;
      if (i_load) r_stage <= i_frame_data;
      if (w_xfer) r_disp <= r_stage;
      r_pend        <= i_load | (r_pend & ~w_xfer);
      if (w_boundary) r_bl <= i_brightness;
      o_frame_start <= w_boundary;
      o_load_ack    <= w_xfer;
      o_com         <= (w_state_nx == S_DRIVE)
                       ? (COM_ACTIVE_LOW ? ~w_onehot : w_onehot)
                       : {NUM_ROWS{COM_ACTIVE_LOW}};
      o_seg         <= (w_state_nx == S_DRIVE) ? w_seg_nx : '0;
    end
  end
endmodule
